// File: rtl/dram_pkg.sv
// Shared types for the DRAM command controller: default widths, FSM states
// and the queued request entry.
package dram_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RSP_HOLD
    } state_t;

    typedef struct packed {
        logic              we;
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] wdata;
    } req_t;

endpackage

// File: rtl/dram_ctrl_req_fifo.sv
// Request queue: DEPTH-entry circular buffer (DEPTH a power of two) with an
// occupancy counter; push is refused when full, pop refused when empty.
module req_fifo
    import dram_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = req_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t din,
    input  logic   pop,
    output entry_t dout,
    output logic   full,
    output logic   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: the storage array has no reset; pointers and count alone define
    // which entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so increment wraps modulo DEPTH.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dram_ctrl.sv
// DRAM command controller: queues load/store commands and issues them to a
// single-port DRAM in order, holding each load result until it is taken.
module dram_ctrl
    import dram_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } entry_t;

    entry_t push_entry;
    entry_t head;
    logic   full;
    logic   empty;
    logic   pop;
    state_t state;

    assign req_ready  = !full;
    assign push_entry = '{we: req_we, addr: req_addr, wdata: req_wdata};
    assign pop        = (state == IDLE) && !empty;

    req_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_valid),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // RD_WAIT spans the read-strobe cycle (mem_read still high) and the
    // following data-return cycle, in which mem_dout is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            // NOTE: strobes default low every cycle so each issue is a single
            // registered pulse; mem_addr/mem_din simply hold their last value.
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        mem_addr <= head.addr;
                        if (head.we) begin
                            mem_write <= 1'b1;
                            mem_din   <= head.wdata;
                        end else begin
                            mem_read <= 1'b1;
                            state    <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (!mem_read) begin
                        rsp_rdata <= mem_dout;
                        rsp_valid <= 1'b1;
                        state     <= RSP_HOLD;
                    end
                end
                RSP_HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dram_ctrl.md
DRAM_CTRL -- requirements
Module: dram_ctrl

Interface
REQ-001 Parameter: DEPTH, default 4, request-queue entries (power of two, >=2).
REQ-002 Parameter: AW, default 16, address width.
REQ-003 Parameter: DW, default 16, data width.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  1  requester offers a command.
REQ-007 req_ready  out  1  queue can accept a command this cycle.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_addr  in  AW  command word address.
REQ-010 req_wdata  in  DW  store data (ignored for loads).
REQ-011 rsp_valid  out  1  load data available.
REQ-012 rsp_ready  in  1  consumer takes load data.
REQ-013 rsp_rdata  out  DW  load data.
REQ-014 mem_read  out  1  to dram read.
REQ-015 mem_write  out  1  to dram write.
REQ-016 mem_addr  out  AW  to dram addr.
REQ-017 mem_din  out  DW  to dram d_in.
REQ-018 mem_dout  in  DW  from dram d_out, valid the cycle after mem_read.

Function
REQ-019 Command accepted on the rising edge where req_valid && req_ready; pushed to FIFO tail.
REQ-020 req_ready SHALL equal !full, independent of req_valid, rsp_ready and same-cycle pops (no push on full even with simultaneous pop).
REQ-021 FIFO pointers SHALL wrap modulo DEPTH; occupancy counter 0..DEPTH; full = count==DEPTH, empty = count==0.
REQ-022 Commands SHALL issue to dram strictly in acceptance order, at most one per cycle, never both mem_read and mem_write.
REQ-023 FSM states: IDLE, RD_WAIT, RSP_HOLD.
REQ-024 IDLE, FIFO non-empty, head store: drive mem_write=1, mem_addr, mem_din from head for exactly one cycle; pop; remain IDLE.
REQ-025 IDLE, FIFO non-empty, head load: drive mem_read=1, mem_addr from head for one cycle; pop; go RD_WAIT.
REQ-026 RD_WAIT: mem_read=mem_write=0; capture mem_dout into rsp_rdata at end of cycle; go RSP_HOLD.
REQ-027 RSP_HOLD: rsp_valid=1, rsp_rdata stable; on rsp_valid && rsp_ready go IDLE; no issue while in RD_WAIT or RSP_HOLD.
REQ-028 mem_read/mem_write/mem_addr/mem_din SHALL be registered outputs; mem_read and mem_write 0 whenever not issuing.
REQ-029 Minimum latency: load accepted at edge E drives mem_read in the cycle after E; rsp_valid high two cycles after that (3 cycles from accept).
REQ-030 Store followed by load to same address SHALL return the stored data (in-order issue guarantees it; no bypass path).
REQ-031 Empty FIFO in IDLE: no dram activity, outputs hold mem_addr/mem_din last values.

Reset
REQ-032 rst_n low SHALL immediately clear: FIFO pointers and count, state=IDLE, mem_read=0, mem_write=0, rsp_valid=0, mem_addr=0, mem_din=0, rsp_rdata=0.
REQ-033 Reset mid-operation SHALL discard queued commands and any in-flight load; no response is produced for them.
REQ-034 req_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-035 Shared package dram_pkg SHALL hold AW/DW defaults, the FSM state enum, and the request-entry struct {we, addr, wdata}.
REQ-036 FIFO SHALL be a separate sub-module req_fifo (parameterised DEPTH, entry type from dram_pkg); FSM and dram drive stay in dram_ctrl.

Verification
REQ-037 Store 0xAAAA to addr 0x0001, then load 0x0001 -> one mem_write cycle (addr 0x0001, din 0xAAAA), then mem_read, rsp_rdata=0xAAAA.
REQ-038 Single load to 0x0002 with rsp_ready=1 from accept -> rsp_valid asserted exactly 3 cycles after accept edge.
REQ-039 Push 5 stores back-to-back with DEPTH=4 while stalled by a held load response -> req_ready=0 after 4th accept; 5th accepted only after a pop.
REQ-040 Hold rsp_ready=0 for 10 cycles on load result 0x1234 -> rsp_valid stays 1, rsp_rdata stays 0x1234, no mem_read/mem_write issued meanwhile.
REQ-041 Assert rst_n=0 in RD_WAIT with 3 queued commands -> mem_read/mem_write/rsp_valid 0 immediately; after release no response and no dram activity.
REQ-042 Run 12 alternating store/load pairs through DEPTH=4 -> all load data match, pointers wrap with no loss or reordering.
